// File: rtl/seq_divider_pkg.sv
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared types and helpers for the sequential divider: FSM state
//             encoding, default operand width, iteration-counter sizing.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Counter must hold 0..WIDTH
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
// ============================================================================
//  Module   : seq_divider_if
//  Purpose  : Start/done handshake and operand/result bus between the ALU
//             (master) and the sequential divider (slave).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, div_zero, quotient, remainder
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, div_zero, quotient, remainder
    );

endinterface

`default_nettype wire

// File: rtl/seq_divider_step.sv
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational non-restoring division iteration on a
//             2*WIDTH+1 bit accumulator {partial remainder, quotient bits}.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [2*WIDTH:0]   i_acc,
    input  wire logic [WIDTH-1:0]   i_dvs_mag,
    output logic      [2*WIDTH:0]   o_acc
);

    logic [WIDTH:0] w_upper;

    // Shift left one place, then add or subtract the divisor depending on the
    // sign of the current partial remainder; new quotient bit is !sign.
    always_comb begin
        if (i_acc[2*WIDTH]) begin
            w_upper = i_acc[2*WIDTH-1:WIDTH-1] + {1'b0, i_dvs_mag};
        end else begin
            w_upper = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_dvs_mag};
        end
        o_acc = {w_upper, i_acc[WIDTH-2:0], ~w_upper[WIDTH]};
    end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Multi-cycle integer divider, one non-restoring step per clock,
//             start/done handshake, defined divide-by-zero results.
//             Optional two's-complement mode enabled by SEQ_DIV_SIGNED_EN;
//             without it, signed_op is ignored and all operations are unsigned.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic   clk,
    input  wire logic   reset,
    seq_divider_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_acc;
    logic [AW-1:0]    w_acc_step;
    logic [WIDTH-1:0] r_dvs_mag;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [CW-1:0]    r_cnt;
    logic             r_dvz;
    logic             w_dvs_zero;
    logic             w_accept;
    logic             w_cnt_last;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_quot_res;
    logic [WIDTH-1:0] w_rem_res;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    assign w_accept   = (r_state == S_IDLE) && bus.start;
    assign w_dvs_zero = (bus.divisor == '0);
    assign w_cnt_last = (r_cnt == CW'(WIDTH - 1));

`ifdef SEQ_DIV_SIGNED_EN
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic r_neg_q;
    logic r_neg_r;

    // Operand magnitudes: negate negative operands in signed mode
    always_comb begin
        w_dvd_neg = bus.signed_op & bus.dividend[WIDTH-1];
        w_dvs_neg = bus.signed_op & bus.divisor[WIDTH-1];
        w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
        w_dvs_mag = w_dvs_neg ? -bus.divisor  : bus.divisor;
    end

    // Sign flags captured at accept: quotient sign is XOR, remainder follows dividend
    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    // Unsigned only: operands are used as-is
    always_comb begin
        w_dvd_mag = bus.dividend;
        w_dvs_mag = bus.divisor;
    end
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc     (r_acc),
        .i_dvs_mag (r_dvs_mag),
        .o_acc     (w_acc_step)
    );

    // Final correction and sign application; divide-by-zero returns the raw dividend
    always_comb begin
        w_q_mag   = r_acc[WIDTH-1:0];
        w_rem_mag = r_acc[AW-1] ? (r_acc[2*WIDTH-1:WIDTH] + r_dvs_mag)
                                :  r_acc[2*WIDTH-1:WIDTH];
        if (r_dvz) begin
            w_quot_res = '1;
            w_rem_res  = r_acc[WIDTH-1:0];
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            w_quot_res = r_neg_q ? -w_q_mag   : w_q_mag;
            w_rem_res  = r_neg_r ? -w_rem_mag : w_rem_mag;
`else
            w_quot_res = w_q_mag;
            w_rem_res  = w_rem_mag;
`endif
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: zero divisor skips RUN entirely
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_dvs_zero ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: load on accept, iterate in RUN, register results in FIX
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_dvs_mag  <= '0;
            r_cnt      <= '0;
            r_dvz      <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc     <= {{(WIDTH+1){1'b0}},
                                      (w_dvs_zero ? bus.dividend : w_dvd_mag)};
                        r_dvs_mag <= w_dvs_mag;
                        r_cnt     <= '0;
                        r_dvz     <= w_dvs_zero;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_quot     <= w_quot_res;
                    r_rem      <= w_rem_res;
                    r_div_zero <= r_dvz;
                    r_done     <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.div_zero  = r_div_zero;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider (scoreboard + monitor,
//             directed corner cases followed by random operations).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

    localparam int W = 32;
`ifdef SEQ_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int unsigned  due;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, truncating division in signed mode
    function automatic exp_t model(input bit sop, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sd, sq, sr;
        e.due = 0;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (sop && SIGNED_EN) begin
            sa   = longint'($signed(a));
            sd   = longint'($signed(b));
            sq   = sa / sd;
            sr   = sa % sd;
            e.q  = sq[W-1:0];
            e.r  = sr[W-1:0];
            e.dz = 1'b0;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Wait for IDLE, present one request, push its expected response
    task automatic do_op(input bit sop, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (bus.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (bus.busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_wait: busy actual 1 required 0 after %0d cycles", guard);
        end
        bus.start     = 1'b1;
        bus.signed_op = sop;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.signed_op = 1'($urandom);
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        e     = model(sop, a, b);
        e.due = edge_cnt + ((b == '0) ? 1 : W + 1);
        sbq.push_back(e);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sbq.size() > 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
    endtask

    // Monitor: compare every done pulse against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: actual done=1 required no pulse (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                check("quotient",  bus.quotient,  e.q);
                check("remainder", bus.remainder, e.r);
                check("div_zero",  W'(bus.div_zero), W'(e.dz));
                check("done_edge", W'(edge_cnt), W'(e.due));
                check("busy_at_done", W'(bus.busy), W'(0));
            end
        end else if (sbq.size() > 0 && edge_cnt > sbq[0].due) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: actual no done by edge %0d required at edge %0d",
                     edge_cnt, sbq[0].due);
            void'(sbq.pop_front());
        end
    end

    initial begin
        logic [W-1:0] a, b;
        bit           sop;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        check("rst_quotient",  bus.quotient,  '0);
        check("rst_remainder", bus.remainder, '0);
        check("rst_busy",      W'(bus.busy),     W'(0));
        check("rst_done",      W'(bus.done),     W'(0));
        check("rst_div_zero",  W'(bus.div_zero), W'(0));
        reset = 1'b0;

        // Basic unsigned with busy window, then back-to-back in the done cycle
        do_op(1'b0, 32'd100, 32'd7);
        for (int k = 0; k < W + 1; k++) begin
            @(negedge clk);
            check("busy_window", W'(bus.busy), W'(1));
        end
        do_op(1'b0, 32'd500, 32'd9);
        wait_drain();

        // Sign combinations, divide by zero, overflow
        do_op(1'b1, -32'sd7, 32'd2);
        do_op(1'b1, 32'd7, -32'sd2);
        do_op(1'b1, -32'sd7, -32'sd2);
        do_op(1'b0, 32'hFFFF_FFF9, 32'd2);
        do_op(1'b0, 32'h0000_1234, 32'd0);
        do_op(1'b1, 32'h0000_1234, 32'd0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_drain();

        // Start pulse during RUN with different operands must be ignored
        do_op(1'b0, 32'd1000, 32'd33);
        repeat (5) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_drain();

        // Reset at edge N+10 aborts the operation; no done for it
        do_op(1'b0, 32'hDEAD_BEEF, 32'd3);
        void'(sbq.pop_back());
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_quotient",  bus.quotient,  '0);
        check("abort_remainder", bus.remainder, '0);
        check("abort_busy",      W'(bus.busy), W'(0));
        check("abort_done",      W'(bus.done), W'(0));
        reset = 1'b0;
        do_op(1'b0, 32'd9, 32'd3);
        wait_drain();

        // Reset and start together: request dropped
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start_busy",     W'(bus.busy), W'(0));
        check("rst_start_quotient", bus.quotient, '0);
        repeat (40) @(negedge clk);

        // Random operations
        for (int i = 0; i < 120; i++) begin
            sop = 1'($urandom);
            a   = $urandom;
            case ($urandom_range(0, 6))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: b = '1;
                3: begin a = 32'h8000_0000; b = $urandom; end
                4: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            do_op(sop, a, b);
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
